// File: rtl/axi4_ar_miss_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : axi4_ar_miss_ctrl
// Description : Read-address miss controller. Turns the L1 TLB verdict for
//               the head AR beat into accept/drop/save, owns the single L2
//               lookup slot (lookup, timed wait, accept/drop), posts miss and
//               protection events to the miss handler and keeps a saturating
//               count of dropped AR beats.
// Revision    : 1.0 - initial release
// ============================================================================
module axi4_ar_miss_ctrl #(
  parameter int AXI_ADDR_WIDTH = 40,
  parameter int AXI_ID_WIDTH   = 4,
  parameter int ENABLE_L2TLB   = 1,
  parameter int L2_TIMEOUT     = 64,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      axi4_aclk,
  input  logic                      axi4_arst,
  // head AR beat at the slave port
  input  logic [AXI_ID_WIDTH-1:0]   s_axi4_arid,
  input  logic [AXI_ADDR_WIDTH-1:0] s_axi4_araddr,
  // L1 verdict and decision
  input  logic                      l1_valid_i,
  input  logic                      l1_hit_i,
  input  logic                      l1_prot_i,
  input  logic                      l1_multi_i,
  output logic                      l1_accept_o,
  output logic                      l1_drop_o,
  output logic                      l1_save_o,
  input  logic                      l1_done_i,
  // L2 lookup slot
  output logic                      l2_lookup_valid_o,
  output logic [AXI_ADDR_WIDTH-1:0] l2_lookup_addr_o,
  input  logic                      l2_lookup_ready_i,
  input  logic                      l2_result_valid_i,
  input  logic                      l2_hit_i,
  input  logic                      l2_prot_i,
  output logic                      l2_accept_o,
  output logic                      l2_drop_o,
  input  logic                      l2_done_i,
  // miss / fault event port
  output logic                      miss_valid_o,
  output logic [AXI_ADDR_WIDTH-1:0] miss_addr_o,
  output logic [AXI_ID_WIDTH-1:0]   miss_id_o,
  output logic                      miss_prot_o,
  input  logic                      miss_ready_i,
  output logic                      miss_ovf_o,
  output logic [CNT_WIDTH-1:0]      drop_cnt_o
);

  // Timer only has to reach L2_TIMEOUT-1, so clog2 bits are enough.
  localparam int c_TMR_W = (L2_TIMEOUT > 1) ? $clog2(L2_TIMEOUT) : 1;
  localparam logic [c_TMR_W-1:0] c_TMR_LAST = c_TMR_W'(L2_TIMEOUT - 1);
  localparam bit c_L2_EN = (ENABLE_L2TLB != 0);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOOKUP = 3'd1,
    ST_WAIT   = 3'd2,
    ST_SEND   = 3'd3,
    ST_DROP   = 3'd4
  } state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [c_TMR_W-1:0]        r_tmr;
  logic                      w_tmr_clr;
  logic                      w_tmr_inc;
  logic [AXI_ADDR_WIDTH-1:0] r_slot_addr;
  logic [AXI_ID_WIDTH-1:0]   r_slot_id;
  logic                      r_slot_prot;
  logic                      w_prot_load;
  logic                      w_prot_val;

  logic                      w_l1_accept;
  logic                      w_l1_drop;
  logic                      w_l1_save;
  logic                      w_save_hs;
  logic                      w_l1_drop_hs;
  logic                      w_l2_drop_hs;

  logic                      r_miss_valid;
  logic [AXI_ADDR_WIDTH-1:0] r_miss_addr;
  logic [AXI_ID_WIDTH-1:0]   r_miss_id;
  logic                      r_miss_prot;
  logic                      r_miss_ovf;
  logic                      w_ev_any;
  logic                      w_ev_can_load;

  logic [CNT_WIDTH-1:0]      r_drop_cnt;
  logic [1:0]                w_cnt_inc;
  logic [CNT_WIDTH:0]        w_cnt_sum;

  // L1 decision: fault beats are dropped, hits pass, misses go to the slot
  // only when it is idle; a miss that finds the slot busy gets no decision
  // and therefore stalls at the head. Forced low while reset is asserted.
  always_comb begin
    w_l1_accept = 1'b0;
    w_l1_drop   = 1'b0;
    w_l1_save   = 1'b0;
    if (!axi4_arst && l1_valid_i) begin
      if (l1_prot_i || l1_multi_i) begin
        w_l1_drop = 1'b1;
      end else if (l1_hit_i) begin
        w_l1_accept = 1'b1;
      end else if (!c_L2_EN) begin
        w_l1_drop = 1'b1;
      end else if (r_state == ST_IDLE) begin
        w_l1_save = 1'b1;
      end
    end
  end

  assign l1_accept_o  = w_l1_accept;
  assign l1_drop_o    = w_l1_drop;
  assign l1_save_o    = w_l1_save;

  assign w_save_hs    = w_l1_save & l1_done_i;
  assign w_l1_drop_hs = w_l1_drop & l1_done_i;
  assign w_l2_drop_hs = (r_state == ST_DROP) & l2_done_i;

  // Slot FSM state register.
  always_ff @(posedge axi4_aclk or posedge axi4_arst) begin
    if (axi4_arst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Slot FSM next state; a result strobe beats a timeout in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_tmr_clr   = 1'b0;
    w_tmr_inc   = 1'b0;
    w_prot_load = 1'b0;
    w_prot_val  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_save_hs) begin
          w_state_nxt = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        if (l2_lookup_ready_i) begin
          w_state_nxt = ST_WAIT;
          w_tmr_clr   = 1'b1;
        end
      end
      ST_WAIT: begin
        if (l2_result_valid_i) begin
          if (l2_hit_i && !l2_prot_i) begin
            w_state_nxt = ST_SEND;
          end else begin
            w_state_nxt = ST_DROP;
            w_prot_load = 1'b1;
            w_prot_val  = l2_prot_i;
          end
        end else if (r_tmr == c_TMR_LAST) begin
          w_state_nxt = ST_DROP;
          w_prot_load = 1'b1;
          w_prot_val  = 1'b0;
        end else begin
          w_tmr_inc = 1'b1;
        end
      end
      ST_SEND: begin
        if (l2_done_i) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_DROP: begin
        if (l2_done_i) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign l2_lookup_valid_o = (r_state == ST_LOOKUP);
  assign l2_lookup_addr_o  = r_slot_addr;
  assign l2_accept_o       = (r_state == ST_SEND);
  assign l2_drop_o         = (r_state == ST_DROP);

  // Slot contents: address/ID on the save handshake, fault flag on entry to DROP.
  always_ff @(posedge axi4_aclk or posedge axi4_arst) begin
    if (axi4_arst) begin
      r_slot_addr <= '0;
      r_slot_id   <= '0;
      r_slot_prot <= 1'b0;
    end else begin
      if (w_save_hs) begin
        r_slot_addr <= s_axi4_araddr;
        r_slot_id   <= s_axi4_arid;
      end
      if (w_prot_load) begin
        r_slot_prot <= w_prot_val;
      end
    end
  end

  // Wait timer, counts cycles spent in WAIT.
  always_ff @(posedge axi4_aclk or posedge axi4_arst) begin
    if (axi4_arst) begin
      r_tmr <= '0;
    end else if (w_tmr_clr) begin
      r_tmr <= '0;
    end else if (w_tmr_inc) begin
      r_tmr <= r_tmr + c_TMR_W'(1);
    end
  end

  assign w_ev_any      = w_l1_drop_hs | w_l2_drop_hs;
  assign w_ev_can_load = !r_miss_valid | miss_ready_i;

  // Single-entry event register; the L2 event wins a same-cycle collision
  // and anything that cannot be stored raises the sticky overflow flag.
  always_ff @(posedge axi4_aclk or posedge axi4_arst) begin
    if (axi4_arst) begin
      r_miss_valid <= 1'b0;
      r_miss_addr  <= '0;
      r_miss_id    <= '0;
      r_miss_prot  <= 1'b0;
      r_miss_ovf   <= 1'b0;
    end else if (w_ev_any) begin
      if (w_ev_can_load) begin
        r_miss_valid <= 1'b1;
        if (w_l2_drop_hs) begin
          r_miss_addr <= r_slot_addr;
          r_miss_id   <= r_slot_id;
          r_miss_prot <= r_slot_prot;
        end else begin
          r_miss_addr <= s_axi4_araddr;
          r_miss_id   <= s_axi4_arid;
          r_miss_prot <= l1_prot_i;
        end
      end
      if (!w_ev_can_load || (w_l1_drop_hs && w_l2_drop_hs)) begin
        r_miss_ovf <= 1'b1;
      end
    end else if (r_miss_valid && miss_ready_i) begin
      r_miss_valid <= 1'b0;
    end
  end

  assign miss_valid_o = r_miss_valid;
  assign miss_addr_o  = r_miss_addr;
  assign miss_id_o    = r_miss_id;
  assign miss_prot_o  = r_miss_prot;
  assign miss_ovf_o   = r_miss_ovf;

  assign w_cnt_inc = {1'b0, w_l1_drop_hs} + {1'b0, w_l2_drop_hs};
  assign w_cnt_sum = {1'b0, r_drop_cnt} + (CNT_WIDTH + 1)'(w_cnt_inc);

  // Saturating drop counter, +1 per drop handshake on either side.
  always_ff @(posedge axi4_aclk or posedge axi4_arst) begin
    if (axi4_arst) begin
      r_drop_cnt <= '0;
    end else if (w_cnt_sum[CNT_WIDTH]) begin
      r_drop_cnt <= '1;
    end else begin
      r_drop_cnt <= w_cnt_sum[CNT_WIDTH-1:0];
    end
  end

  assign drop_cnt_o = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_axi4_ar_miss_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi4_ar_miss_ctrl
// Description : Self-checking bench. Two instances share one stimulus stream:
//               [0] default parameters, [1] L2 disabled with a 2-bit counter.
//               A transaction-level model predicts every output each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi4_ar_miss_ctrl;

  localparam int AW = 40;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [IW-1:0] arid;
  logic [AW-1:0] araddr;
  logic          l1_valid, l1_hit, l1_prot, l1_multi, l1_done;
  logic          lk_ready, res_valid, l2_hit, l2_prot, l2_done, miss_ready;

  logic          l1_accept [2];
  logic          l1_drop   [2];
  logic          l1_save   [2];
  logic          lk_valid  [2];
  logic [AW-1:0] lk_addr   [2];
  logic          l2_accept [2];
  logic          l2_drop   [2];
  logic          ev_valid  [2];
  logic [AW-1:0] ev_addr   [2];
  logic [IW-1:0] ev_id     [2];
  logic          ev_prot   [2];
  logic          ev_ovf    [2];
  logic [15:0]   cnt0;
  logic [1:0]    cnt1;

  always #5 clk = ~clk;

  axi4_ar_miss_ctrl u_dut0 (
    .axi4_aclk(clk), .axi4_arst(rst), .s_axi4_arid(arid), .s_axi4_araddr(araddr),
    .l1_valid_i(l1_valid), .l1_hit_i(l1_hit), .l1_prot_i(l1_prot), .l1_multi_i(l1_multi),
    .l1_accept_o(l1_accept[0]), .l1_drop_o(l1_drop[0]), .l1_save_o(l1_save[0]), .l1_done_i(l1_done),
    .l2_lookup_valid_o(lk_valid[0]), .l2_lookup_addr_o(lk_addr[0]), .l2_lookup_ready_i(lk_ready),
    .l2_result_valid_i(res_valid), .l2_hit_i(l2_hit), .l2_prot_i(l2_prot),
    .l2_accept_o(l2_accept[0]), .l2_drop_o(l2_drop[0]), .l2_done_i(l2_done),
    .miss_valid_o(ev_valid[0]), .miss_addr_o(ev_addr[0]), .miss_id_o(ev_id[0]),
    .miss_prot_o(ev_prot[0]), .miss_ready_i(miss_ready), .miss_ovf_o(ev_ovf[0]),
    .drop_cnt_o(cnt0));

  axi4_ar_miss_ctrl #(.ENABLE_L2TLB(0), .CNT_WIDTH(2)) u_dut1 (
    .axi4_aclk(clk), .axi4_arst(rst), .s_axi4_arid(arid), .s_axi4_araddr(araddr),
    .l1_valid_i(l1_valid), .l1_hit_i(l1_hit), .l1_prot_i(l1_prot), .l1_multi_i(l1_multi),
    .l1_accept_o(l1_accept[1]), .l1_drop_o(l1_drop[1]), .l1_save_o(l1_save[1]), .l1_done_i(l1_done),
    .l2_lookup_valid_o(lk_valid[1]), .l2_lookup_addr_o(lk_addr[1]), .l2_lookup_ready_i(lk_ready),
    .l2_result_valid_i(res_valid), .l2_hit_i(l2_hit), .l2_prot_i(l2_prot),
    .l2_accept_o(l2_accept[1]), .l2_drop_o(l2_drop[1]), .l2_done_i(l2_done),
    .miss_valid_o(ev_valid[1]), .miss_addr_o(ev_addr[1]), .miss_id_o(ev_id[1]),
    .miss_prot_o(ev_prot[1]), .miss_ready_i(miss_ready), .miss_ovf_o(ev_ovf[1]),
    .drop_cnt_o(cnt1));

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  // slot phase: 0 free, 1 requesting lookup, 2 awaiting result, 3 granting, 4 refusing
  localparam int TMO = 64;
  bit            m_en   [2] = '{1'b1, 1'b0};
  int            m_cmax [2] = '{65535, 3};
  int            m_phase[2];
  int            m_wait [2];
  logic [AW-1:0] m_saddr[2];
  logic [IW-1:0] m_sid  [2];
  logic          m_sprot[2];
  logic          m_ev_v [2];
  logic [AW-1:0] m_ev_a [2];
  logic [IW-1:0] m_ev_i [2];
  logic          m_ev_p [2];
  logic          m_ovf  [2];
  int            m_cnt  [2];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_phase[k] = 0; m_wait[k] = 0; m_saddr[k] = '0; m_sid[k] = '0; m_sprot[k] = 1'b0;
      m_ev_v[k] = 1'b0; m_ev_a[k] = '0; m_ev_i[k] = '0; m_ev_p[k] = 1'b0;
      m_ovf[k] = 1'b0; m_cnt[k] = 0;
    end
  endtask

  // 0 none, 1 accept, 2 drop, 3 save
  function automatic int model_dec(input int k);
    if (rst || !l1_valid) return 0;
    if (l1_prot || l1_multi) return 2;
    if (l1_hit) return 1;
    if (!m_en[k]) return 2;
    if (m_phase[k] == 0) return 3;
    return 0;
  endfunction

  task automatic check_model();
    for (int k = 0; k < 2; k++) begin
      int d;
      d = model_dec(k);
      chk($sformatf("l1_accept[%0d]", k), 64'(l1_accept[k]), 64'(d == 1));
      chk($sformatf("l1_drop[%0d]", k),   64'(l1_drop[k]),   64'(d == 2));
      chk($sformatf("l1_save[%0d]", k),   64'(l1_save[k]),   64'(d == 3));
      chk($sformatf("lk_valid[%0d]", k),  64'(lk_valid[k]),  64'(m_phase[k] == 1));
      if (m_phase[k] == 1) chk($sformatf("lk_addr[%0d]", k), 64'(lk_addr[k]), 64'(m_saddr[k]));
      chk($sformatf("l2_accept[%0d]", k), 64'(l2_accept[k]), 64'(m_phase[k] == 3));
      chk($sformatf("l2_drop[%0d]", k),   64'(l2_drop[k]),   64'(m_phase[k] == 4));
      chk($sformatf("ev_valid[%0d]", k),  64'(ev_valid[k]),  64'(m_ev_v[k]));
      if (m_ev_v[k]) begin
        chk($sformatf("ev_addr[%0d]", k), 64'(ev_addr[k]), 64'(m_ev_a[k]));
        chk($sformatf("ev_id[%0d]", k),   64'(ev_id[k]),   64'(m_ev_i[k]));
        chk($sformatf("ev_prot[%0d]", k), 64'(ev_prot[k]), 64'(m_ev_p[k]));
      end
      chk($sformatf("ev_ovf[%0d]", k), 64'(ev_ovf[k]), 64'(m_ovf[k]));
      chk($sformatf("drop_cnt[%0d]", k), (k == 0) ? 64'(cnt0) : 64'(cnt1), 64'(m_cnt[k]));
    end
  endtask

  // Advances the model over one rising edge using the inputs now applied.
  task automatic model_step();
    if (rst) begin
      model_reset();
      return;
    end
    for (int k = 0; k < 2; k++) begin
      int  d;
      bit  e1, e2;
      d  = model_dec(k);
      e1 = (d == 2) && l1_done;
      e2 = (m_phase[k] == 4) && l2_done;
      if (e1 || e2) begin
        if (!m_ev_v[k] || miss_ready) begin
          m_ev_v[k] = 1'b1;
          if (e2) begin
            m_ev_a[k] = m_saddr[k]; m_ev_i[k] = m_sid[k]; m_ev_p[k] = m_sprot[k];
          end else begin
            m_ev_a[k] = araddr; m_ev_i[k] = arid; m_ev_p[k] = l1_prot;
          end
          if (e1 && e2) m_ovf[k] = 1'b1;
        end else begin
          m_ovf[k] = 1'b1;
        end
      end else if (m_ev_v[k] && miss_ready) begin
        m_ev_v[k] = 1'b0;
      end
      m_cnt[k] = m_cnt[k] + int'(e1) + int'(e2);
      if (m_cnt[k] > m_cmax[k]) m_cnt[k] = m_cmax[k];
      case (m_phase[k])
        0: if (d == 3 && l1_done) begin m_phase[k] = 1; m_saddr[k] = araddr; m_sid[k] = arid; end
        1: if (lk_ready) begin m_phase[k] = 2; m_wait[k] = 0; end
        2: begin
          if (res_valid) begin
            if (l2_hit && !l2_prot) m_phase[k] = 3;
            else begin m_phase[k] = 4; m_sprot[k] = l2_prot; end
          end else if (m_wait[k] == TMO - 1) begin
            m_phase[k] = 4; m_sprot[k] = 1'b0;
          end else begin
            m_wait[k]++;
          end
        end
        default: if (l2_done) m_phase[k] = 0;
      endcase
    end
  endtask

  // Called #1 after a falling edge with inputs stable; returns at the next falling edge.
  task automatic tick();
    check_model();
    model_step();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    arid = '0; araddr = '0; l1_valid = 0; l1_hit = 0; l1_prot = 0; l1_multi = 0; l1_done = 0;
    lk_ready = 0; res_valid = 0; l2_hit = 0; l2_prot = 0; l2_done = 0;
  endtask

  task automatic head(input logic [AW-1:0] a, input logic [IW-1:0] id,
                      input logic h, input logic p, input logic dn);
    l1_valid = 1; araddr = a; arid = id; l1_hit = h; l1_prot = p; l1_multi = 0; l1_done = dn;
  endtask

  initial begin
    logic [63:0] r64;
    bit  head_v, silent;
    int  bias, rst_left;

    idle_inputs();
    miss_ready = 1;
    rst = 1;
    model_reset();

    // ---- reset state ----
    @(negedge clk); #1;
    chk("rst_l1_accept", 64'(l1_accept[0]), 64'd0);
    chk("rst_lk_valid",  64'(lk_valid[0]),  64'd0);
    chk("rst_l2_drop",   64'(l2_drop[0]),   64'd0);
    chk("rst_ev_valid",  64'(ev_valid[0]),  64'd0);
    chk("rst_cnt",       64'(cnt0),         64'd0);
    tick();
    rst = 0; #1; tick();

    // ---- L1 hit: accept same cycle, no event ----
    head(40'h1000, 4'd3, 1, 0, 1); #1;
    chk("hit_accept", 64'(l1_accept[0]), 64'd1);
    chk("hit_drop",   64'(l1_drop[0]),   64'd0);
    tick();
    idle_inputs(); #1;
    chk("hit_no_event", 64'(ev_valid[0]), 64'd0);
    chk("hit_cnt",      64'(cnt0),        64'd0);
    tick();

    // ---- L1 protection fault: drop, event next cycle ----
    head(40'h2000, 4'd1, 1, 1, 1); #1;
    chk("prot_drop", 64'(l1_drop[0]), 64'd1);
    tick();
    idle_inputs(); #1;
    chk("prot_ev_valid", 64'(ev_valid[0]), 64'd1);
    chk("prot_ev_addr",  64'(ev_addr[0]),  64'h2000);
    chk("prot_ev_prot",  64'(ev_prot[0]),  64'd1);
    chk("prot_cnt",      64'(cnt0),        64'd1);
    tick();

    // ---- L1 miss: save, lookup, L2 hit after 5 cycles ----
    head(40'h3000, 4'd5, 0, 0, 1); #1;
    chk("miss_save", 64'(l1_save[0]), 64'd1);
    tick();
    idle_inputs(); lk_ready = 1; res_valid = 1; l2_prot = 1; #1;
    chk("lookup_valid", 64'(lk_valid[0]), 64'd1);
    chk("lookup_addr",  64'(lk_addr[0]),  64'h3000);
    tick();
    idle_inputs();
    head(40'h4000, 4'd6, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("busy_no_save", 64'(l1_save[0]), 64'd0);
      tick();
    end
    res_valid = 1; l2_hit = 1; #1; tick();
    res_valid = 0; l2_hit = 0; #1;
    chk("l2_accept", 64'(l2_accept[0]), 64'd1);
    tick();
    #1; tick();
    l2_done = 1; #1;
    chk("l2_accept_done", 64'(l2_accept[0]), 64'd1);
    chk("no_same_cycle_reuse", 64'(l1_save[0]), 64'd0);
    tick();
    l2_done = 0; l1_done = 1; #1;
    chk("save_after_idle", 64'(l1_save[0]), 64'd1);
    chk("l2_accept_off",   64'(l2_accept[0]), 64'd0);
    tick();

    // ---- L2 never answers: drop at WAIT cycle 64 ----
    idle_inputs(); lk_ready = 1; #1;
    chk("lookup_addr2", 64'(lk_addr[0]), 64'h4000);
    tick();
    idle_inputs();
    for (int i = 0; i < TMO; i++) begin
      #1;
      chk("wait_no_drop", 64'(l2_drop[0]), 64'd0);
      tick();
    end
    l2_done = 1; #1;
    chk("timeout_drop", 64'(l2_drop[0]), 64'd1);
    tick();
    l2_done = 0; #1;
    chk("to_ev_valid", 64'(ev_valid[0]), 64'd1);
    chk("to_ev_addr",  64'(ev_addr[0]),  64'h4000);
    chk("to_ev_prot",  64'(ev_prot[0]),  64'd0);
    chk("to_cnt",      64'(cnt0),        64'd2);
    tick();

    // ---- two drops with handler stalled: first held, overflow set ----
    miss_ready = 0;
    head(40'h6000, 4'd2, 0, 1, 1); #1; tick();
    head(40'h7000, 4'd2, 0, 1, 1); #1; tick();
    idle_inputs(); #1;
    chk("ovf_ev_addr", 64'(ev_addr[0]), 64'h6000);
    chk("ovf_flag",    64'(ev_ovf[0]),  64'd1);
    chk("ovf_cnt",     64'(cnt0),       64'd4);
    chk("sat_cnt2",    64'(cnt1),       64'd3);
    tick();
    miss_ready = 1; #1; tick();

    // ---- randomized traffic ----
    head_v = 0; silent = 0; bias = 80; rst_left = 0;
    for (int cyc = 0; cyc < 6000; cyc++) begin
      if (cyc % 256 == 0) bias = $urandom_range(10, 100);
      if (rst_left > 0) begin
        rst_left--;
        if (rst_left == 0) rst = 0;
      end else if ($urandom_range(0, 1499) == 0) begin
        rst = 1; rst_left = 2; head_v = 0; model_reset();
      end
      if (!head_v && $urandom_range(0, 2) == 0) begin
        int kind;
        r64 = {$urandom, $urandom};
        araddr = r64[AW-1:0];
        arid = IW'($urandom);
        kind = $urandom_range(0, 9);
        l1_prot  = (kind < 2);
        l1_multi = (kind == 2);
        l1_hit   = (kind >= 3 && kind <= 6) || (kind < 2 && $urandom_range(0, 1) == 1);
        head_v = 1;
      end
      l1_valid = head_v;
      l1_done  = head_v && !rst && (model_dec(0) != 0) && ($urandom_range(0, 3) != 0);
      if (l1_done && model_dec(0) == 3) silent = ($urandom_range(0, 3) == 0);
      lk_ready   = ($urandom_range(0, 2) == 0);
      res_valid  = !silent && ($urandom_range(0, 5) == 0);
      l2_hit     = ($urandom_range(0, 1) == 1);
      l2_prot    = ($urandom_range(0, 3) == 0);
      l2_done    = ($urandom_range(0, 1) == 1);
      miss_ready = ($urandom_range(1, 100) <= bias);
      #1;
      tick();
      if (l1_done) head_v = 0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
